// File: rtl/array_alloc_requester_pkg.sv
// Shared types for the array-length store interface: store bus payload,
// requester FSM states and the reserved tombstone address.
package array_alloc_requester_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LEN_W  = 32;

   localparam logic [ADDR_W-1:0] TOMB_ADDR = 32'hFFFF_FFFF;

   typedef struct packed {
      logic              mode;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } astore_in_bus_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RESTART,
      ST_ARM,
      ST_SEARCH,
      ST_RESP
   } areq_state_t;

   // Address span consumed by an array; zero-length arrays still take one slot.
   function automatic logic [LEN_W-1:0] span_of(input logic [LEN_W-1:0] len);
      span_of = (len == '0) ? LEN_W'(1) : len;
   endfunction

endpackage

// File: rtl/search_timer.sv
// Loadable up-counter bounding a store lookup; expired_c flags the enabled
// cycle in which the count reaches TIMEOUT.
module search_timer #(
   parameter int unsigned TIMEOUT = 1028,
   parameter int unsigned CNT_W   = 11
) (
   input  logic             clk,
   input  logic             r,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired_c
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_inc;

   always_comb begin
      count_inc = count_q + CNT_W'(1);
      count_d   = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = count_inc;
      end
   end

   assign expired_c = en && (count_inc == CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (r) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/array_alloc_requester.sv
// Initiator for the array-length store: hands out array base addresses from a
// bump pointer, registers (addr, len) pairs and runs bounded length lookups.
module array_alloc_requester
   import array_alloc_requester_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
   parameter int unsigned MAX_ENTRIES    = 1024,
   parameter int unsigned SEARCH_TIMEOUT = MAX_ENTRIES + 4,
   parameter logic [31:0] TOMB_ADDR      = array_alloc_requester_pkg::TOMB_ADDR
) (
   input  logic           clk,
   input  logic           r,
   input  logic           alloc_valid,
   output logic           alloc_ready,
   input  logic [31:0]    alloc_len,
   input  logic           q_valid,
   output logic           q_ready,
   input  logic [31:0]    q_addr,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_kind,
   output logic [31:0]    rsp_data,
   output logic           rsp_found,
   output logic           rsp_err,
   output astore_in_bus_t a_out,
   input  logic [31:0]    st_len,
   input  logic           st_found,
   input  logic           st_finished
);

   localparam int unsigned ENT_W = $clog2(MAX_ENTRIES + 1);
   localparam int unsigned TMR_W = $clog2(SEARCH_TIMEOUT + 1);

   areq_state_t    state_q, state_d;
   logic [31:0]    ptr_q, ptr_d;
   logic [ENT_W-1:0] entries_q, entries_d;
   logic           searched_q, searched_d;
   logic [31:0]    alloc_len_q, alloc_len_d;
   logic [31:0]    q_addr_q, q_addr_d;
   logic           alloc_ready_q, alloc_ready_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_kind_q, rsp_kind_d;
   logic [31:0]    rsp_data_q, rsp_data_d;
   logic           rsp_found_q, rsp_found_d;
   logic           rsp_err_q, rsp_err_d;
   astore_in_bus_t a_out_q, a_out_d;

   logic           alloc_acc_c;
   logic           q_acc_c;
   logic           table_full_c;
   logic [32:0]    alloc_sum_c;
   logic           timer_clr_c;
   logic           timer_en_c;
   logic           timer_expired_c;

   search_timer #(
      .TIMEOUT (SEARCH_TIMEOUT),
      .CNT_W   (TMR_W)
   ) u_search_timer (
      .clk       (clk),
      .r         (r),
      .clr       (timer_clr_c),
      .en        (timer_en_c),
      .load      (1'b0),
      .load_val  ('0),
      .expired_c (timer_expired_c)
   );

   // Alloc wins arbitration, so q_ready must drop combinationally in that cycle.
   assign q_ready      = alloc_ready_q && !alloc_valid;
   assign alloc_acc_c  = (state_q == ST_IDLE) && alloc_ready_q && alloc_valid;
   assign q_acc_c      = (state_q == ST_IDLE) && alloc_ready_q && q_valid && !alloc_valid;
   assign table_full_c = (entries_q == ENT_W'(MAX_ENTRIES));
   assign alloc_sum_c  = {1'b0, ptr_q} + {1'b0, span_of(alloc_len)};

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      entries_d   = entries_q;
      searched_d  = searched_q;
      alloc_len_d = alloc_len_q;
      q_addr_d    = q_addr_q;
      rsp_kind_d  = rsp_kind_q;
      rsp_data_d  = rsp_data_q;
      rsp_found_d = rsp_found_q;
      rsp_err_d   = rsp_err_q;
      a_out_d     = '0;
      timer_clr_c = 1'b0;
      timer_en_c  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (alloc_acc_c) begin
               alloc_len_d = alloc_len;
               rsp_kind_d  = 1'b0;
               rsp_data_d  = '0;
               rsp_found_d = 1'b0;
               rsp_err_d   = 1'b0;
               if (table_full_c || alloc_sum_c[32]) begin
                  state_d   = ST_RESP;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d      = ST_WRITE;
                  a_out_d.mode = 1'b1;
                  a_out_d.addr = ptr_q;
                  a_out_d.len  = alloc_len;
               end
            end else if (q_acc_c) begin
               q_addr_d    = q_addr;
               rsp_kind_d  = 1'b1;
               rsp_data_d  = '0;
               rsp_found_d = 1'b0;
               rsp_err_d   = 1'b0;
               if (q_addr == TOMB_ADDR) begin
                  state_d = ST_RESP;
               end else if (searched_q) begin
                  // A finished lookup leaves the store stale; a tombstone write rearms it.
                  if (table_full_c) begin
                     state_d   = ST_RESP;
                     rsp_err_d = 1'b1;
                  end else begin
                     state_d      = ST_RESTART;
                     a_out_d.mode = 1'b1;
                     a_out_d.addr = TOMB_ADDR;
                  end
               end else begin
                  state_d      = ST_ARM;
                  a_out_d.addr = q_addr;
               end
            end
         end
         ST_WRITE: begin
            ptr_d      = ptr_q + span_of(alloc_len_q);
            entries_d  = entries_q + ENT_W'(1);
            searched_d = 1'b0;
            rsp_data_d = ptr_q;
            state_d    = ST_RESP;
         end
         ST_RESTART: begin
            entries_d    = entries_q + ENT_W'(1);
            state_d      = ST_ARM;
            a_out_d.addr = q_addr_q;
         end
         ST_ARM: begin
            searched_d   = 1'b1;
            timer_clr_c  = 1'b1;
            state_d      = ST_SEARCH;
            a_out_d.addr = q_addr_q;
         end
         ST_SEARCH: begin
            timer_en_c = 1'b1;
            if (st_finished && st_found) begin
               state_d     = ST_RESP;
               rsp_data_d  = st_len;
               rsp_found_d = 1'b1;
            end else if (timer_expired_c) begin
               state_d = ST_RESP;
            end else begin
               a_out_d.addr = q_addr_q;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_kind_d  = 1'b0;
               rsp_data_d  = '0;
               rsp_found_d = 1'b0;
               rsp_err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      alloc_ready_d = (state_d == ST_IDLE);
      rsp_valid_d   = (state_d == ST_RESP);
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state_q       <= ST_IDLE;
         ptr_q         <= BASE_ADDR;
         entries_q     <= '0;
         searched_q    <= 1'b0;
         alloc_len_q   <= '0;
         q_addr_q      <= '0;
         alloc_ready_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_kind_q    <= 1'b0;
         rsp_data_q    <= '0;
         rsp_found_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         a_out_q       <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         entries_q     <= entries_d;
         searched_q    <= searched_d;
         alloc_len_q   <= alloc_len_d;
         q_addr_q      <= q_addr_d;
         alloc_ready_q <= alloc_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_kind_q    <= rsp_kind_d;
         rsp_data_q    <= rsp_data_d;
         rsp_found_q   <= rsp_found_d;
         rsp_err_q     <= rsp_err_d;
         a_out_q       <= a_out_d;
      end
   end

   assign alloc_ready = alloc_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_kind    = rsp_kind_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_found   = rsp_found_q;
   assign rsp_err     = rsp_err_q;
   assign a_out       = a_out_q;

endmodule

// File: tb/tb_array_alloc_requester.sv
// Directed bench for array_alloc_requester with a small behavioural length
// store: 2-cycle arm, one entry compared per cycle, misses never finish.
module tb_array_alloc_requester;
   import array_alloc_requester_pkg::*;

   logic           clk = 1'b0;
   logic           r = 1'b1;
   logic           alloc_valid = 1'b0;
   logic           alloc_ready;
   logic [31:0]    alloc_len = '0;
   logic           q_valid = 1'b0;
   logic           q_ready;
   logic [31:0]    q_addr = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic           rsp_kind;
   logic [31:0]    rsp_data;
   logic           rsp_found;
   logic           rsp_err;
   astore_in_bus_t a_out;
   logic [31:0]    st_len;
   logic           st_found;
   logic           st_finished;

   int errors = 0;
   int checks = 0;

   array_alloc_requester #(
      .MAX_ENTRIES (4)
   ) dut (
      .clk         (clk),
      .r           (r),
      .alloc_valid (alloc_valid),
      .alloc_ready (alloc_ready),
      .alloc_len   (alloc_len),
      .q_valid     (q_valid),
      .q_ready     (q_ready),
      .q_addr      (q_addr),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_kind    (rsp_kind),
      .rsp_data    (rsp_data),
      .rsp_found   (rsp_found),
      .rsp_err     (rsp_err),
      .a_out       (a_out),
      .st_len      (st_len),
      .st_found    (st_found),
      .st_finished (st_finished)
   );

   always #5 clk = ~clk;

   // Store model: any write rearms it; entry k is reported 2+k cycles after the
   // lookup address first appears, and a hit is held until the next write.
   logic [31:0] st_a [0:15];
   logic [31:0] st_l [0:15];
   int          st_n;
   int          st_cnt;
   logic        st_fresh;

   always @(posedge clk) begin
      if (r) begin
         st_n        <= 0;
         st_cnt      <= 0;
         st_fresh    <= 1'b0;
         st_found    <= 1'b0;
         st_finished <= 1'b0;
         st_len      <= '0;
      end else if (a_out.mode) begin
         if (st_n < 16) begin
            st_a[st_n] <= a_out.addr;
            st_l[st_n] <= a_out.len;
         end
         st_n        <= st_n + 1;
         st_cnt      <= 0;
         st_fresh    <= 1'b1;
         st_found    <= 1'b0;
         st_finished <= 1'b0;
         st_len      <= '0;
      end else if (st_fresh && a_out.addr != 32'd0) begin
         st_cnt <= st_cnt + 1;
         if (st_cnt >= 1 && st_cnt - 1 < st_n && st_cnt - 1 < 16) begin
            if (st_a[st_cnt-1] == a_out.addr) begin
               st_found    <= 1'b1;
               st_finished <= 1'b1;
               st_len      <= st_l[st_cnt-1];
               st_fresh    <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic acc_alloc(input logic [31:0] len, output astore_in_bus_t bus0);
      int n = 0;
      while (alloc_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("alloc_ready_pre", 65'(alloc_ready), 65'(1));
      alloc_valid = 1'b1;
      alloc_len   = len;
      @(posedge clk);
      @(negedge clk);
      alloc_valid = 1'b0;
      bus0 = a_out;
   endtask

   task automatic acc_query(input logic [31:0] addr, output astore_in_bus_t bus0);
      int n = 0;
      while (q_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("q_ready_pre", 65'(q_ready), 65'(1));
      q_valid = 1'b1;
      q_addr  = addr;
      @(posedge clk);
      @(negedge clk);
      q_valid = 1'b0;
      bus0 = a_out;
   endtask

   // Edges after the accepting edge until rsp_valid is visible.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic do_alloc(input string tag, input logic [31:0] len, input logic [64:0] exp_bus,
                           input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
      astore_in_bus_t bus0;
      int lat;
      acc_alloc(len, bus0);
      chk({tag, "_bus"}, 65'(bus0), exp_bus);
      wait_rsp(lat);
      chk({tag, "_lat"}, 65'(lat), 65'(exp_lat));
      chk({tag, "_bus_resp"}, 65'(a_out), 65'(0));
      chk({tag, "_kind"}, 65'(rsp_kind), 65'(0));
      chk({tag, "_data"}, 65'(rsp_data), 65'(exp_data));
      chk({tag, "_err"}, 65'(rsp_err), 65'(exp_err));
      @(negedge clk);
   endtask

   task automatic do_query(input string tag, input logic [31:0] addr, input logic [64:0] exp_bus,
                           input int exp_lat, input logic exp_found, input logic [31:0] exp_data,
                           input logic exp_err);
      astore_in_bus_t bus0;
      int lat;
      acc_query(addr, bus0);
      chk({tag, "_bus"}, 65'(bus0), exp_bus);
      wait_rsp(lat);
      chk({tag, "_lat"}, 65'(lat), 65'(exp_lat));
      chk({tag, "_kind"}, 65'(rsp_kind), 65'(1));
      chk({tag, "_found"}, 65'(rsp_found), 65'(exp_found));
      chk({tag, "_data"}, 65'(rsp_data), 65'(exp_data));
      chk({tag, "_err"}, 65'(rsp_err), 65'(exp_err));
      @(negedge clk);
   endtask

   initial begin
      astore_in_bus_t bus0;
      int lat;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_alloc_ready", 65'(alloc_ready), 65'(0));
      chk("rst_q_ready", 65'(q_ready), 65'(0));
      chk("rst_rsp_valid", 65'(rsp_valid), 65'(0));
      chk("rst_bus", 65'(a_out), 65'(0));
      r = 1'b0;
      @(negedge clk);
      chk("idle_alloc_ready", 65'(alloc_ready), 65'(1));
      chk("idle_q_ready", 65'(q_ready), 65'(1));

      // Allocations and lookups; MAX_ENTRIES=4, SEARCH_TIMEOUT=8
      do_alloc("a5", 32'd5, {1'b1, 32'h1000, 32'd5}, 1, 32'h1000, 1'b0);
      do_alloc("a0", 32'd0, {1'b1, 32'h1005, 32'd0}, 1, 32'h1005, 1'b0);
      do_query("q1005", 32'h1005, {1'b0, 32'h1005, 32'd0}, 4, 1'b1, 32'd0, 1'b0);
      do_query("q1000_rst", 32'h1000, {1'b1, 32'hFFFF_FFFF, 32'd0}, 4, 1'b1, 32'd5, 1'b0);
      do_alloc("a3", 32'd3, {1'b1, 32'h1006, 32'd3}, 1, 32'h1006, 1'b0);
      do_query("q2000_miss", 32'h2000, {1'b0, 32'h2000, 32'd0}, 9, 1'b0, 32'd0, 1'b0);
      do_query("qtomb", 32'hFFFF_FFFF, 65'(0), 0, 1'b0, 32'd0, 1'b0);

      // Table full: error with no store write, response held under back-pressure
      rsp_ready = 1'b0;
      acc_alloc(32'd1, bus0);
      chk("full_bus", 65'(bus0), 65'(0));
      wait_rsp(lat);
      chk("full_lat", 65'(lat), 65'(0));
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", 65'(rsp_valid), 65'(1));
         chk("hold_err", 65'(rsp_err), 65'(1));
         chk("hold_data", 65'(rsp_data), 65'(0));
         chk("hold_kind", 65'(rsp_kind), 65'(0));
         chk("hold_bus", 65'(a_out), 65'(0));
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_released", 65'(rsp_valid), 65'(0));
      do_query("q_full_rst", 32'h1000, 65'(0), 0, 1'b0, 32'd0, 1'b1);

      // Fresh reset: overflow, then simultaneous alloc and query
      r = 1'b1;
      @(negedge clk);
      r = 1'b0;
      @(negedge clk);
      do_alloc("a_ovf", 32'hFFFF_FFFF, 65'(0), 0, 32'd0, 1'b1);
      alloc_valid = 1'b1;
      alloc_len   = 32'd7;
      q_valid     = 1'b1;
      q_addr      = 32'h1000;
      #1;
      chk("arb_q_ready", 65'(q_ready), 65'(0));
      chk("arb_alloc_ready", 65'(alloc_ready), 65'(1));
      @(posedge clk);
      @(negedge clk);
      alloc_valid = 1'b0;
      chk("arb_bus", 65'(a_out), {1'b1, 32'h1000, 32'd7});
      wait_rsp(lat);
      chk("arb_alloc_lat", 65'(lat), 65'(1));
      chk("arb_alloc_kind", 65'(rsp_kind), 65'(0));
      chk("arb_alloc_data", 65'(rsp_data), 65'(32'h1000));
      @(negedge clk);
      chk("arb_q_ready_after", 65'(q_ready), 65'(1));
      @(posedge clk);
      @(negedge clk);
      q_valid = 1'b0;
      chk("arb_q_bus", 65'(a_out), {1'b0, 32'h1000, 32'd0});
      wait_rsp(lat);
      chk("arb_q_lat", 65'(lat), 65'(3));
      chk("arb_q_kind", 65'(rsp_kind), 65'(1));
      chk("arb_q_found", 65'(rsp_found), 65'(1));
      chk("arb_q_data", 65'(rsp_data), 65'(7));
      @(negedge clk);

      // Reset while a lookup is in SEARCH
      acc_query(32'h3000, bus0);
      chk("mid_bus_restart", 65'(bus0), {1'b1, 32'hFFFF_FFFF, 32'd0});
      repeat (3) @(negedge clk);
      chk("mid_search_bus", 65'(a_out), {1'b0, 32'h3000, 32'd0});
      r = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 65'(rsp_valid), 65'(0));
      chk("mid_rst_bus", 65'(a_out), 65'(0));
      chk("mid_rst_ready", 65'(alloc_ready), 65'(0));
      r = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid2", 65'(rsp_valid), 65'(0));
      do_query("post_rst_miss", 32'h1000, {1'b0, 32'h1000, 32'd0}, 9, 1'b0, 32'd0, 1'b0);
      do_alloc("post_rst_ptr", 32'd2, {1'b1, 32'h1000, 32'd2}, 1, 32'h1000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
